data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the core's data-memory port: serves load/store
//  requests (word address, write data, write enable) and returns read data.
//  Valid/ready handshake on both request and response channels, with a
//  programmable wait-state counter so the core's memory path runs against
//  realistic latency. Word-addressed storage array, range/alignment error flag.
// PARAMETERS
//  WIDTH        32   data word width in bits
//  DEPTH        256  number of words; ADDR_W = $clog2(DEPTH)
//  WAIT_CYCLES  2    wait states between request accept and response (0..15)
// PORTS
//  Clk        input   1      clock, rising edge
//  Rst        input   1      asynchronous reset, active-low
//  Req_Valid  input   1      request present
//  Req_Ready  output  1      responder can accept a request (state IDLE)
//  Req_WE     input   1      1 = store, 0 = load
//  Req_Addr   input   32     byte address; word index = Req_Addr[ADDR_W+1:2]
//  Req_WData  input   WIDTH  store data
//  Resp_Valid output  1      response present
//  Resp_Ready input   1      requester takes the response
//  Resp_RData output  WIDTH  load data; 0 for stores and errored accesses
//  Resp_Err   output  1      access out of range or misaligned
//  Busy       output  1      state is WAIT or RESP
// BEHAVIOUR
//  - Reset (Rst=0, async): state IDLE; Req_Ready=1, Resp_Valid=0,
//    Resp_RData=0, Resp_Err=0, Busy=0, wait counter=0. Array not reset.
//  - FSM: IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: Req_Ready=1. Accept on edge with Req_Valid&Req_Ready. Latch
//      WE/index/wdata/error; counter loads WAIT_CYCLES. If WAIT_CYCLES=0,
//      perform access at this edge and go to RESP; else go to WAIT.
//    WAIT: Req_Ready=0; counter decrements each edge; at the edge where
//      counter==1, perform access, go to RESP.
//    RESP: Resp_Valid=1; Resp_RData/Resp_Err held stable until the edge
//      with Resp_Valid&Resp_Ready, then IDLE (Resp_Valid=0, RData/Err -> 0).
//  - Latency: Resp_Valid rises exactly WAIT_CYCLES+1 edges after the accept
//    edge (WAIT_CYCLES=0: visible in the cycle right after accept).
//  - Access: store writes latched wdata to array[index] at the access edge;
//    load registers array[index] into Resp_RData at the access edge.
//  - Range: Req_Addr[31:ADDR_W+2] != 0 -> Resp_Err=1, store suppressed,
//    Resp_RData=0. Error still completes through full FSM/latency.
//  - No request pipelining: Req_Ready=0 in WAIT and RESP; Req_Valid there is
//    ignored (requester must hold it). Next accept earliest one cycle after
//    the response handshake, i.e. max 1 transaction per WAIT_CYCLES+2 cycles.
//  - Inputs sampled only at the accept edge; later changes have no effect.
//  - Reset mid-operation: pending transaction dropped; a store not yet at
//    its access edge is never written; stores already committed persist.
// CONFIGURATION
//  MISALIGN_CHECK_EN defined: Req_Addr[1:0]!=0 sets Resp_Err=1, store
//    suppressed, Resp_RData=0 (same path as range error).
//  MISALIGN_CHECK_EN undefined: Req_Addr[1:0] ignored; access uses the
//    word index; Resp_Err reflects range only.
// TESTING
//  1 WAIT=2: store 0xDEADBEEF @0x10 -> Resp_Valid 3 edges after accept,
//    Err=0, RData=0; load @0x10 -> RData=0xDEADBEEF, Err=0.
//  2 Resp_Ready low 5 cycles in RESP -> Resp_Valid/RData/Err stable,
//    Req_Ready=0, concurrent Req_Valid (store @0x14) not accepted/written.
//  3 DEPTH=256: store 0x1234 @0x400 -> Err=1; load @0x0 returns prior
//    value; load @0x400 -> Err=1, RData=0.
//  4 store 0xA5A5A5A5 @0x13: with MISALIGN_CHECK_EN Err=1, @0x10 unchanged;
//    without it Err=0 and load @0x10 = 0xA5A5A5A5.
//  5 Rst low during WAIT of store 0x77 @0x20 -> after release IDLE,
//    Req_Ready=1, Resp_Valid=0; load @0x20 returns pre-store value.
//  6 WAIT=0, Req_Valid & Resp_Ready held 1, 4 loads -> each Resp_Valid one
//    cycle after accept, accepts every 2nd cycle, RData matches array.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the core's data-memory port and its responder.
interface data_mem_responder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [31:0]      req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder with valid/ready channels and programmable wait states.
// Define MISALIGN_CHECK_EN to flag byte addresses with Req_Addr[1:0] != 0 as errors.
module data_mem_responder #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    data_mem_responder_if.slave bus,
    output logic                busy
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic              we;
        logic              err;
        logic [ADDR_W-1:0] idx;
        logic [WIDTH-1:0]  wdata;
    } req_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_q, req_d, in_req, acc_req;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             ready_q, valid_q, busy_q;
    logic             access_c;
    logic             range_err_c, align_err_c;
    logic [WIDTH-1:0] mem [DEPTH];

    // Any address bit above the word index makes the access out of range
    assign range_err_c = (bus.req_addr >> (ADDR_W + 2)) != 32'd0;
`ifdef MISALIGN_CHECK_EN
    assign align_err_c = bus.req_addr[1:0] != 2'b00;
`else
    assign align_err_c = 1'b0;
`endif

    always_comb begin
        in_req       = '0;
        in_req.we    = bus.req_we;
        in_req.err   = range_err_c | align_err_c;
        in_req.idx   = bus.req_addr[ADDR_W+1:2];
        in_req.wdata = bus.req_wdata;
    end

    // Next state; with zero wait states the access uses the request straight off the bus
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        access_c = 1'b0;
        acc_req  = req_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid && ready_q) begin
                    req_d = in_req;
                    cnt_d = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        access_c = 1'b1;
                        acc_req  = in_req;
                        state_d  = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    access_c = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (access_c) begin
            err_d   = acc_req.err;
            rdata_d = (acc_req.we || acc_req.err) ? '0 : mem[acc_req.idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ready_q <= (state_d == S_IDLE);
            valid_q <= (state_d == S_RESP);
            busy_q  <= (state_d != S_IDLE);
        end
    end

    // Storage array is intentionally not reset; errored stores never commit
    always_ff @(posedge clk) begin
        if (access_c && acc_req.we && !acc_req.err) begin
            mem[acc_req.idx] <= acc_req.wdata;
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder: one instance with two wait states, one with none.
`timescale 1ns/1ps
module tb_data_mem_responder;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned WAIT_N = 2;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    logic busy, busy0;

    data_mem_responder_if #(.WIDTH(WIDTH)) bus  ();
    data_mem_responder_if #(.WIDTH(WIDTH)) bus0 ();

    data_mem_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_N)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
    );
    data_mem_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sbq[$];
    logic [31:0] model  [int];
    logic [31:0] model0 [int];
    int vectors     = 0;
    int miscompares = 0;

    // Expected error for a 256-word array: any bit above 9 set, plus misalignment if enabled
    function automatic logic addr_err(input logic [31:0] a);
        logic e;
        e = (a[31:10] != 22'd0);
`ifdef MISALIGN_CHECK_EN
        e = e | (a[1:0] != 2'b00);
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [31:0] rdata, input logic err);
        exp_t e;
        if (sbq.size() == 0) begin
            check({tag, "/sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            check({tag, "/rdata"}, rdata, e.rdata);
            check({tag, "/err"}, 32'(err), 32'(e.err));
        end
    endtask

    // One transaction on the wait-state instance; optional response back-pressure and a rival request
    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input int hold, input bit poke, input string tag);
        exp_t e;
        int   n;
        int   idx;
        idx     = int'(a[9:2]);
        e.err   = addr_err(a);
        e.rdata = (we || e.err) ? 32'h0 : (model.exists(idx) ? model[idx] : 32'hxxxx_xxxx);
        if (we && !e.err) model[idx] = d;
        sbq.push_back(e);
        check({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
        @(posedge clk); @(negedge clk);
        bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_addr = 32'h0000_03FC; bus.req_wdata = 32'h5A5A_0F0F;
        n = 1;
        while (!bus.resp_valid && n < 20) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        check({tag, "/latency"}, 32'(n), 32'(WAIT_N + 1));
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h14; bus.req_wdata = 32'hBAD0_BAD0;
            end
            @(posedge clk); @(negedge clk);
            check({tag, "/hold_valid"}, 32'(bus.resp_valid), 32'd1);
            check({tag, "/hold_ready"}, 32'(bus.req_ready), 32'd0);
            check({tag, "/hold_rdata"}, bus.resp_rdata, e.rdata);
            check({tag, "/hold_err"}, 32'(bus.resp_err), 32'(e.err));
        end
        bus.req_valid = 1'b0;
        pop_check(tag, bus.resp_rdata, bus.resp_err);
        bus.resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.resp_ready = 1'b0;
        check({tag, "/post_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "/post_rdata"}, bus.resp_rdata, 32'd0);
        check({tag, "/post_err"}, 32'(bus.resp_err), 32'd0);
        check({tag, "/post_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [31:0] t6_addr [8];
    logic [31:0] t6_data [8];
    initial begin
        exp_t e;
        int   idx;
        rst_n = 1'b0;
        bus.req_valid  = 1'b0; bus.req_we  = 1'b0; bus.req_addr  = '0; bus.req_wdata  = '0; bus.resp_ready  = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0; bus0.resp_ready = 1'b0;
        t6_addr = '{32'h40, 32'h44, 32'h3FC, 32'h100, 32'h100, 32'h40, 32'h3FC, 32'h44};
        t6_data = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 0, 0, 0, 0};

        // reset state
        repeat (2) @(negedge clk);
        check("rst/req_ready", 32'(bus.req_ready), 32'd1);
        check("rst/resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst/rdata", bus.resp_rdata, 32'd0);
        check("rst/err", 32'(bus.resp_err), 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic store/load
        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, "t1_st");
        txn(1'b0, 32'h10, 32'h0, 0, 1'b0, "t1_ld");

        // back-pressure with a rival store that must be ignored
        txn(1'b1, 32'h14, 32'h1414_1414, 0, 1'b0, "t2_pre");
        txn(1'b0, 32'h10, 32'h0, 5, 1'b1, "t2_hold");
        txn(1'b0, 32'h14, 32'h0, 0, 1'b0, "t2_ld14");

        // out-of-range accesses
        txn(1'b1, 32'h0, 32'hCAFE_0000, 0, 1'b0, "t3_st0");
        txn(1'b1, 32'h400, 32'h1234, 0, 1'b0, "t3_st_oor");
        txn(1'b0, 32'h0, 32'h0, 0, 1'b0, "t3_ld0");
        txn(1'b0, 32'h400, 32'h0, 2, 1'b0, "t3_ld_oor");

        // misaligned store
        txn(1'b1, 32'h13, 32'hA5A5_A5A5, 0, 1'b0, "t4_st");
        txn(1'b0, 32'h10, 32'h0, 0, 1'b0, "t4_ld");

        // reset while a store sits in WAIT
        txn(1'b1, 32'h20, 32'h55, 0, 1'b0, "t5_pre");
        check("t5/req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'h77;
        @(posedge clk); @(negedge clk);
        bus.req_valid = 1'b0;
        check("t5/busy_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check("t5/rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("t5/rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("t5/rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t5/idle_req_ready", 32'(bus.req_ready), 32'd1);
        check("t5/idle_resp_valid", 32'(bus.resp_valid), 32'd0);
        txn(1'b0, 32'h20, 32'h0, 0, 1'b0, "t5_ld");

        // zero wait states, request and response ready held high
        bus0.resp_ready = 1'b1;
        bus0.req_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus0.req_we    = (i < 4);
            bus0.req_addr  = t6_addr[i];
            bus0.req_wdata = t6_data[i];
            idx     = int'(t6_addr[i][9:2]);
            e.err   = addr_err(t6_addr[i]);
            e.rdata = (i < 4 || e.err) ? 32'h0 : (model0.exists(idx) ? model0[idx] : 32'hxxxx_xxxx);
            if (i < 4 && !e.err) model0[idx] = t6_data[i];
            sbq.push_back(e);
            check($sformatf("t6_%0d/req_ready", i), 32'(bus0.req_ready), 32'd1);
            @(posedge clk); @(negedge clk);
            check($sformatf("t6_%0d/resp_valid", i), 32'(bus0.resp_valid), 32'd1);
            check($sformatf("t6_%0d/busy", i), 32'(busy0), 32'd1);
            pop_check($sformatf("t6_%0d", i), bus0.resp_rdata, bus0.resp_err);
            @(posedge clk); @(negedge clk);
            check($sformatf("t6_%0d/resp_done", i), 32'(bus0.resp_valid), 32'd0);
        end
        bus0.req_valid  = 1'b0;
        bus0.resp_ready = 1'b0;

        check("end/sb_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
